// File: rtl/mem_wb_stage_hs.sv
// MEM-stage controller with a req/ack data-memory handshake, branch/jump/return
// resolution, timeout watchdog and the MEM/WB pipeline register.
module mem_wb_stage_hs #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int WBW     = 4,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ex_valid,
    output logic           ex_ready,
    input  logic           ex_ld,
    input  logic           ex_st,
    input  logic           ex_ret,
    input  logic           ex_jmp,
    input  logic [2:0]     ex_br_cond,
    input  logic [3:0]     ex_flags,
    input  logic [DW-1:0]  ex_alu,
    input  logic [DW-1:0]  ex_sdata,
    input  logic [DW-1:0]  ex_baddr,
    input  logic [DW-1:0]  ex_jaddr,
    input  logic [WBW-1:0] ex_wb,
    input  logic [AW-1:0]  ex_waddr,
    output logic           mem_req,
    output logic           mem_we,
    output logic [DW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    input  logic           mem_ack,
    output logic           redirect_valid,
    output logic [DW-1:0]  redirect_pc,
    output logic           bus_err,
    output logic           wb_valid,
    output logic [WBW-1:0] wb_wb,
    output logic [DW-1:0]  wb_mdata,
    output logic [DW-1:0]  wb_alu,
    output logic [AW-1:0]  wb_waddr
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic WDOG_EN = (TIMEOUT > 0);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [DW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_bus_err;
    logic            r_wb_valid_p1;
    logic [WBW-1:0]  r_wb_wb_p1;
    logic [DW-1:0]   r_wb_mdata_p1;
    logic [DW-1:0]   r_wb_alu_p1;
    logic [AW-1:0]   r_wb_waddr_p1;

    logic            w_mem_op;
    logic            w_ack;
    logic            w_abort;
    logic            w_retire;
    logic            w_taken;
    logic            w_unused;

    function automatic logic f_taken(input logic [2:0] cond, input logic z, input logic n);
        logic t;
        case (cond)
            3'b001:  t = z;
            3'b010:  t = ~z;
            3'b011:  t = z | n;
            3'b100:  t = ~z & ~n;
            3'b101:  t = n & ~z;
            3'b110:  t = ~n;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign w_unused = ^ex_flags[3:2];
    assign w_mem_op = ex_ld | ex_st | ex_ret;
    assign w_ack    = (r_state == S_WAIT) & mem_ack;
    // An ack arriving in the last watchdog cycle takes precedence over the abort.
    assign w_abort  = WDOG_EN & (r_state == S_WAIT) & ~mem_ack & (r_cnt == CNT_LAST);
    assign ex_ready = (r_state == S_IDLE) ? ~(ex_valid & w_mem_op) : (mem_ack | w_abort);
    assign w_retire = ex_valid & ex_ready;
    assign w_taken  = f_taken(ex_br_cond, ex_flags[0], ex_flags[1]);

    assign redirect_valid = w_retire & ~w_abort & (ex_ret | ex_jmp | w_taken);
    assign redirect_pc    = ex_ret ? mem_rdata : (ex_jmp ? ex_jaddr : ex_baddr);

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign bus_err   = r_bus_err;

    // stage p0 -> memory handshake FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_valid & w_mem_op) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= ex_st;
                        r_mem_addr  <= ex_alu;
                        r_mem_wdata <= ex_sdata;
                        r_cnt       <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack | w_abort) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_bus_err <= w_abort;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // stage p1 -> MEM/WB register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid_p1 <= 1'b0;
            r_wb_wb_p1    <= '0;
            r_wb_mdata_p1 <= '0;
            r_wb_alu_p1   <= '0;
            r_wb_waddr_p1 <= '0;
        end else begin
            r_wb_valid_p1 <= w_retire;
            if (w_retire) begin
                r_wb_wb_p1    <= w_abort ? '0 : ex_wb;
                r_wb_mdata_p1 <= (w_ack & (ex_ld | ex_ret)) ? mem_rdata : '0;
                r_wb_alu_p1   <= ex_alu;
                r_wb_waddr_p1 <= ex_waddr;
            end
        end
    end

    assign wb_valid = r_wb_valid_p1;
    assign wb_wb    = r_wb_wb_p1;
    assign wb_mdata = r_wb_mdata_p1;
    assign wb_alu   = r_wb_alu_p1;
    assign wb_waddr = r_wb_waddr_p1;

endmodule

// File: tb/tb_mem_wb_stage_hs.sv
// Bench for mem_wb_stage_hs: directed steps plus randomized transactions checked
// against a per-transaction outcome model derived from the stage's rules.
module tb_mem_wb_stage_hs;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_ld, ex_st, ex_ret, ex_jmp;
    logic [2:0]  ex_br_cond;
    logic [3:0]  ex_flags;
    logic [31:0] ex_alu, ex_sdata, ex_baddr, ex_jaddr;
    logic [3:0]  ex_wb;
    logic [4:0]  ex_waddr;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        redirect_valid, bus_err, wb_valid;
    logic [31:0] redirect_pc, wb_mdata, wb_alu;
    logic [3:0]  wb_wb;
    logic [4:0]  wb_waddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage_hs #(.DW(32), .AW(5), .WBW(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ld(ex_ld), .ex_st(ex_st),
        .ex_ret(ex_ret), .ex_jmp(ex_jmp), .ex_br_cond(ex_br_cond), .ex_flags(ex_flags),
        .ex_alu(ex_alu), .ex_sdata(ex_sdata), .ex_baddr(ex_baddr), .ex_jaddr(ex_jaddr),
        .ex_wb(ex_wb), .ex_waddr(ex_waddr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .bus_err(bus_err),
        .wb_valid(wb_valid), .wb_wb(wb_wb), .wb_mdata(wb_mdata), .wb_alu(wb_alu),
        .wb_waddr(wb_waddr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Branch outcome straight from the condition table (Z = flag bit0, N = bit1).
    function automatic bit model_taken(input logic [2:0] cond, input logic [3:0] fl);
        bit z = fl[0];
        bit n = fl[1];
        case (cond)
            3'd1: return z;
            3'd2: return !z;
            3'd3: return z || n;
            3'd4: return !z && !n;
            3'd5: return n && !z;
            3'd6: return !n;
            default: return 0;
        endcase
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_ld = 0; ex_st = 0; ex_ret = 0; ex_jmp = 0;
        ex_br_cond = 0; ex_flags = 0; ex_alu = 0; ex_sdata = 0; ex_baddr = 0;
        ex_jaddr = 0; ex_wb = 0; ex_waddr = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    // Presents one entry, plays the memory (ack in mem_req cycle 'lat', none if lat<0
    // or lat>=TO), and checks every cycle through the writeback cycle.
    task automatic run_txn(input bit ld, input bit st, input bit ret, input bit jmp,
                           input logic [2:0] cond, input logic [3:0] fl,
                           input logic [31:0] alu, input logic [31:0] sdata,
                           input logic [31:0] baddr, input logic [31:0] jaddr,
                           input logic [31:0] rdata, input logic [3:0] wb,
                           input logic [4:0] waddr, input int lat);
        bit mop = ld || st || ret;
        bit aborted;
        bit redir;
        int rc;
        int reqs = 0;
        logic [31:0] pc;
        if (!mop) begin
            rc = 0; aborted = 0;
        end else if (lat >= 0 && lat <= TO - 1) begin
            rc = lat + 1; aborted = 0;
        end else begin
            rc = TO; aborted = 1;
        end
        redir = !aborted && (ret || jmp || model_taken(cond, fl));
        pc = ret ? rdata : (jmp ? jaddr : baddr);

        ex_valid = 1; ex_ld = ld; ex_st = st; ex_ret = ret; ex_jmp = jmp;
        ex_br_cond = cond; ex_flags = fl; ex_alu = alu; ex_sdata = sdata;
        ex_baddr = baddr; ex_jaddr = jaddr; ex_wb = wb; ex_waddr = waddr;
        for (int i = 0; i <= rc; i++) begin
            mem_ack = mop && (lat >= 0) && (i == lat + 1);
            mem_rdata = mem_ack ? rdata : $urandom;
            @(negedge clk);
            chk("ex_ready", ex_ready, (i == rc));
            chk("mem_req", mem_req, (mop && i >= 1));
            if (mem_req) reqs++;
            if (mop && i >= 1) begin
                chk("mem_addr", mem_addr, alu);
                chk("mem_we", mem_we, st);
                if (st) chk("mem_wdata", mem_wdata, sdata);
            end
            chk("redirect_valid", redirect_valid, (i == rc) ? redir : 1'b0);
            if (i == rc && redir) chk("redirect_pc", redirect_pc, pc);
            chk("bus_err_wait", bus_err, 1'b0);
            chk("wb_valid_wait", wb_valid, 1'b0);
            @(posedge clk); #1;
        end
        ex_valid = 0; mem_ack = 0; mem_rdata = $urandom;
        @(negedge clk);
        chk("req_cycles", reqs, mop ? rc : 0);
        chk("mem_req_after", mem_req, 1'b0);
        chk("ex_ready_idle", ex_ready, 1'b1);
        chk("bus_err", bus_err, aborted);
        chk("wb_valid", wb_valid, 1'b1);
        chk("wb_wb", wb_wb, aborted ? 4'h0 : wb);
        chk("wb_alu", wb_alu, alu);
        chk("wb_waddr", wb_waddr, waddr);
        chk("wb_mdata", wb_mdata, (!aborted && (ld || ret)) ? rdata : 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_wb_alu", wb_alu, 32'h0);
        chk("rst_wb_mdata", wb_mdata, 32'h0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;

        // ALU op, load with ack after 3 cycles, store that times out
        run_txn(0, 0, 0, 0, 3'd0, 4'h0, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0, 4'h5, 5'd7, -1);
        run_txn(1, 0, 0, 0, 3'd0, 4'h0, 32'h40, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 4'h3, 5'd2, 3);
        run_txn(0, 1, 0, 0, 3'd1, 4'h1, 32'h80, 32'hA5A5A5A5, 32'h300, 32'h0, 32'h0, 4'h9, 5'd3, -1);
        // ack in the would-be abort cycle, and immediate ack
        run_txn(1, 0, 0, 0, 3'd0, 4'h0, 32'h44, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 4'h7, 5'd4, TO - 1);
        run_txn(0, 1, 0, 0, 3'd0, 4'h0, 32'h48, 32'h11112222, 32'h0, 32'h0, 32'h0, 4'h1, 5'd5, 0);

        // branch sweep over every condition and Z/N combination
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 4; f++) begin
                run_txn(0, 0, 0, 0, 3'(c), 4'(f), 32'h10 + 32'(c), 32'h0, 32'h100 + 32'(c * 4 + f),
                        32'h0, 32'h0, 4'h2, 5'(c + f), -1);
            end
        end

        // return beats jump, redirect only in the ack cycle
        run_txn(1, 0, 1, 1, 3'd1, 4'h1, 32'h60, 32'h0, 32'h500, 32'h700, 32'h2000, 4'hF, 5'd31, 2);
        // return that times out: no redirect, no load data
        run_txn(0, 0, 1, 1, 3'd0, 4'h0, 32'h64, 32'h0, 32'h0, 32'h700, 32'h2004, 4'hE, 5'd30, -1);

        // async reset while waiting on memory
        ex_valid = 1; ex_ld = 1; ex_alu = 32'h90; ex_wb = 4'h6; ex_waddr = 5'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_mem_req", mem_req, 1'b1);
        #2 rst = 0;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_wb_valid", wb_valid, 1'b0);
        chk("midrst_bus_err", bus_err, 1'b0);
        idle_inputs();
        #1;
        chk("midrst_ex_ready", ex_ready, 1'b1);
        @(posedge clk); #2;
        rst = 1;
        @(posedge clk); #1;
        run_txn(1, 0, 0, 0, 3'd0, 4'h0, 32'h94, 32'h0, 32'h0, 32'h0, 32'h13572468, 4'h6, 5'd9, 1);

        // randomized transactions
        for (int k = 0; k < 150; k++) begin
            bit rl, rs, rr, rj;
            int lat;
            rl = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 5) == 0);
            rj = ($urandom_range(0, 3) == 0);
            lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO)) : int'($urandom_range(0, 3));
            run_txn(rl, rs, rr, rj, 3'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                    $urandom, $urandom, 4'($urandom), 5'($urandom), lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage_hs.md
Name: mem_wb_stage_hs

Overview:
Parametrised MEM-stage controller and MEM/WB pipeline register for the pipelined MIPS core.
- Resolves branches, jumps and return-from-stack, and drives a single-cycle PC redirect toward stage 1.
- Replaces the fixed single-cycle memory access with a req/ack handshake to a variable-latency data memory.
- Provides upstream stall, a timeout watchdog and a valid-qualified writeback bundle.

Parameters:
DW, 32, data/address width
AW, 5, register-file write-address width
WBW, 4, writeback control width
TIMEOUT, 15, max WAIT cycles before abort; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ex_valid  in  1  EX/MEM entry present
ex_ready  out  1  entry retires this cycle; upstream holds inputs while low
ex_ld  in  1  load
ex_st  in  1  store
ex_ret  in  1  load PC from memory (ISR/return); implies a load
ex_jmp  in  1  unconditional jump
ex_br_cond  in  3  000 none, 001 eq, 010 ne, 011 le, 100 gt, 101 lt, 110 ge, 111 none
ex_flags  in  4  bit0 Z, bit1 N, bits3:2 unused
ex_alu  in  DW  ALU result / memory address / jump-register target
ex_sdata  in  DW  store data
ex_baddr  in  DW  branch target
ex_jaddr  in  DW  jump target
ex_wb  in  WBW  writeback control
ex_waddr  in  AW  write register
mem_req  out  1  memory request, held until ack or abort
mem_we  out  1  write enable
mem_addr  out  DW  address
mem_wdata  out  DW  write data
mem_rdata  in  DW  read data, valid with mem_ack
mem_ack  in  1  single-cycle completion
redirect_valid  out  1  PC redirect (combinational, asserted in the retire cycle)
redirect_pc  out  DW  new PC
bus_err  out  1  one-cycle pulse on timeout abort
wb_valid  out  1  writeback entry valid
wb_wb  out  WBW  writeback control
wb_mdata  out  DW  loaded data
wb_alu  out  DW  ALU result
wb_waddr  out  AW  write register

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; counter=0.
  - mem_req, mem_we, bus_err, wb_valid = 0; all other registered outputs = 0.
  - Reset mid-WAIT drops mem_req immediately; the entry is discarded.
- mem_op = ex_ld | ex_st | ex_ret.
- FSM states IDLE, WAIT.
- IDLE:
  - ex_valid & ~mem_op: ex_ready=1; retire this cycle.
  - ex_valid & mem_op: ex_ready=0. Next edge registers mem_req=1, mem_we=ex_st, mem_addr=ex_alu, mem_wdata=ex_sdata, counter=0; go to WAIT.
  - ~ex_valid: ex_ready=1, nothing retires.
- WAIT:
  - mem_ack: ex_ready=1; retire. Next edge: mem_req=0, go to IDLE.
  - No ack: counter increments.
  - counter==TIMEOUT-1 without ack (TIMEOUT>0): abort. ex_ready=1, retire with wb_wb forced to 0, no redirect. Next edge: bus_err=1 for one cycle, mem_req=0, go to IDLE.
  - mem_ack in the abort cycle: ack wins; normal retire, no bus_err.
- Retire (ex_valid & ex_ready) loads on the next edge:
  - wb_valid=1; wb_wb=ex_wb; wb_alu=ex_alu; wb_waddr=ex_waddr.
  - wb_mdata = mem_rdata if a load retired on ack, else 0.
- No retire: wb_valid=0 on the next edge; other wb_* hold.
- Branch taken conditions:
  - eq: Z
  - ne: ~Z
  - le: Z|N
  - gt: ~Z&~N
  - lt: N&~Z
  - ge: ~N
- redirect_valid = retire & ~abort & (ex_ret | ex_jmp | taken).
- redirect_pc priority:
  - ex_ret → mem_rdata
  - ex_jmp → ex_jaddr
  - taken → ex_baddr
- Upstream must hold all ex_* stable while ex_ready=0.
- mem_* change only on clock edges.
- Minimum load latency: presented in cycle N, mem_req in N+1, retire on the ack cycle, wb_valid the cycle after.

Test Plan:
- ALU op, ex_alu=0x1234, ex_waddr=7, ex_valid 1 cycle → ex_ready=1 same cycle; next cycle wb_valid=1, wb_alu=0x1234, wb_waddr=7; no mem_req.
- Load, ex_alu=0x40, ack 3 cycles after mem_req, mem_rdata=0xDEADBEEF → ex_ready low 4 cycles; mem_addr=0x40; wb_mdata=0xDEADBEEF with wb_valid one cycle after ack.
- Store, ex_sdata=0xA5A5A5A5, no ack, TIMEOUT=15 → mem_req held 15 cycles; bus_err pulses once; wb_valid=1 with wb_wb=0; redirect_valid never asserted.
- Branch sweep with no memory op:
  - cond=001, Z=1, ex_baddr=0x100 → redirect_valid=1, redirect_pc=0x100.
  - cond=100, N=1 → redirect_valid=0.
  - All 6 conditions × 4 Z/N combinations checked.
- ex_ret with ex_jmp=1, mem_rdata=0x2000, ack → redirect_pc=0x2000 (ret wins), asserted only in the ack cycle.
- rst low during WAIT, then released → mem_req=0 immediately; state IDLE; wb_valid=0; a new load issues normally after release.
